// File: rtl/exec_sequencer.sv
// exec_sequencer
// Controls instruction issue for a small CPU.
// It has four modes: idle, single-step, free-running at RUN_DIV clk cycles
// per instruction, and halt.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   step_pb, resume_pb  debounced pushbutton levels (rising edge = press)
//   run_sw              1 = free run
//   bp_en, bp_addr      breakpoint enable and PC to stop at
//   pc, instruction     current PC and instruction word
//   cpu_en              one-cycle pulse per retired instruction
//   state               0 IDLE, 1 STEP, 2 RUN, 3 HALT
//   halted              state == HALT
//   halt_cause          00 none, 01 breakpoint, 10 halt opcode
//   instr_count         saturating count of cpu_en pulses
module exec_sequencer #(
    parameter int         RUN_DIV     = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_pb,
    input  logic        resume_pb,
    input  logic        run_sw,
    input  logic        bp_en,
    input  logic [8:0]  bp_addr,
    input  logic [8:0]  pc,
    input  logic [15:0] instruction,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_OP   = 2'b10;

    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic        bp_skip_q, bp_skip_d;
    logic [15:0] count_q, count_d;
    logic        step_prev_q, resume_prev_q;

    logic step_edge, resume_edge;
    logic op_hit, bp_hit, hc, issue_pt;

    assign step_edge   = step_pb & ~step_prev_q;
    assign resume_edge = resume_pb & ~resume_prev_q;

    assign op_hit = (instruction[15:12] == HALT_OPCODE);
    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip_q;
    assign hc     = op_hit | bp_hit;

    // Issue point counts only while still in run mode; dropping run_sw wins.
    assign issue_pt = (state_q == RUN) && run_sw && (div_cnt_q == DIV_LAST);

    // Reset gates the pulse in the same cycle it is asserted.
    assign cpu_en = !reset && ((state_q == STEP) || (issue_pt && !hc));

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        cause_d   = cause_q;
        bp_skip_d = bp_skip_q;
        count_d   = count_q;

        case (state_q)
            IDLE: begin
                if (run_sw) begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                end else if (step_edge) begin
                    if (hc) begin
                        state_d = HALT;
                        cause_d = op_hit ? CAUSE_OP : CAUSE_BP;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: state_d = IDLE;
            RUN: begin
                if (!run_sw) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (hc) begin
                        state_d = HALT;
                        cause_d = op_hit ? CAUSE_OP : CAUSE_BP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            HALT: begin
                // A halt opcode is terminal; only reset leaves.
                if (cause_q == CAUSE_BP && resume_edge) begin
                    state_d   = IDLE;
                    cause_d   = CAUSE_NONE;
                    bp_skip_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The skip covers exactly one retired instruction at the breakpoint PC.
        if (cpu_en) begin
            bp_skip_d = 1'b0;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            cause_q       <= CAUSE_NONE;
            bp_skip_q     <= 1'b0;
            count_q       <= '0;
            // Loading 1 means a button held through reset shows no edge.
            step_prev_q   <= 1'b1;
            resume_prev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            cause_q       <= cause_d;
            bp_skip_q     <= bp_skip_d;
            count_q       <= count_d;
            step_prev_q   <= step_pb;
            resume_prev_q <= resume_pb;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == HALT);
    assign halt_cause  = cause_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer (RUN_DIV = 4).
// Each expected cpu_en pulse goes into a queue as the cycle number on which
// it should appear. A monitor pops one entry for every observed pulse.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_pb, resume_pb, run_sw, bp_en;
    logic [8:0]  bp_addr, pc;
    logic [15:0] instruction;
    logic        cpu_en, halted;
    logic [1:0]  state, halt_cause;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_q[$];
    logic prev_en = 1'b0;

    exec_sequencer #(.RUN_DIV(4), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .reset(reset), .step_pb(step_pb), .resume_pb(resume_pb),
        .run_sw(run_sw), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .instruction(instruction), .cpu_en(cpu_en), .state(state),
        .halted(halted), .halt_cause(halt_cause), .instr_count(instr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press_step(input bit want_pulse);
        if (want_pulse) exp_q.push_back(cyc + 1);
        step_pb = 1'b1;
        tick(1);
        step_pb = 1'b0;
        tick(2);
    endtask

    task automatic press_resume();
        resume_pb = 1'b1;
        tick(1);
        resume_pb = 1'b0;
        tick(1);
    endtask

    task automatic drain(input string tag);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            chk("back_to_back", int'(prev_en), 0);
            if (exp_q.size() == 0) chk("unexpected_pulse", int'(cpu_en), 0);
            else                   chk("pulse_cycle", cyc, exp_q.pop_front());
        end
        prev_en = cpu_en;
    end

    initial begin
        int c0;
        reset = 1'b1; step_pb = 0; resume_pb = 0; run_sw = 0; bp_en = 0;
        bp_addr = 9'd0; pc = 9'd10; instruction = 16'h1234;
        tick(3);
        chk("rst_state", int'(state), 0);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_cause", int'(halt_cause), 0);
        chk("rst_count", int'(instr_count), 0);
        reset = 1'b0;
        tick(1);

        // Three single steps
        for (int i = 0; i < 3; i++) press_step(1'b1);
        chk("step_count", int'(instr_count), 3);
        chk("step_state", int'(state), 0);
        drain("step_drain");

        // Free run for 17 cycles: pulses on RUN cycles 4, 8, 12, 16
        do_reset();
        c0 = cyc;
        run_sw = 1'b1;
        for (int k = 4; k <= 16; k += 4) exp_q.push_back(c0 + k);
        tick(1);
        chk("run_state", int'(state), 2);
        tick(16);
        run_sw = 1'b0;
        tick(1);
        chk("run_exit_state", int'(state), 0);
        chk("run_count", int'(instr_count), 4);
        drain("run_drain");

        // Reset asserted on an issue cycle kills that pulse
        do_reset();
        run_sw = 1'b1;
        tick(4);
        chk("pre_reset_en", int'(cpu_en), 1);
        reset = 1'b1;
        #1;
        chk("reset_gates_en", int'(cpu_en), 0);
        run_sw = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("mid_run_rst_state", int'(state), 0);
        chk("mid_run_rst_count", int'(instr_count), 0);

        // Breakpoint stop, resume, one step past it, then re-arm
        tick(1);
        bp_en = 1'b1; bp_addr = 9'd5; pc = 9'd3; instruction = 16'h1000;
        c0 = cyc;
        run_sw = 1'b1;
        exp_q.push_back(c0 + 4);
        tick(5);
        pc = 9'd5;
        tick(5);
        chk("bp_state", int'(state), 3);
        chk("bp_halted", int'(halted), 1);
        chk("bp_cause", int'(halt_cause), 1);
        chk("bp_count", int'(instr_count), 1);
        run_sw = 1'b0;
        tick(1);
        press_resume();
        chk("resume_state", int'(state), 0);
        chk("resume_cause", int'(halt_cause), 0);
        press_step(1'b1);
        chk("skip_count", int'(instr_count), 2);
        press_step(1'b0);
        chk("rearm_state", int'(state), 3);
        chk("rearm_cause", int'(halt_cause), 1);
        drain("bp_drain");

        // Halt opcode with breakpoint also matching: opcode wins, terminal
        do_reset();
        bp_en = 1'b1; bp_addr = 9'd0; pc = 9'd1; instruction = 16'h1000;
        run_sw = 1'b1;
        tick(2);
        pc = 9'd0; instruction = 16'hF000;
        tick(4);
        chk("op_state", int'(state), 3);
        chk("op_cause", int'(halt_cause), 2);
        instruction = 16'h1000; pc = 9'd1; run_sw = 1'b0;
        tick(1);
        press_resume();
        press_step(1'b0);
        run_sw = 1'b1;
        tick(6);
        run_sw = 1'b0;
        tick(6);
        chk("op_stuck_state", int'(state), 3);
        chk("op_stuck_cause", int'(halt_cause), 2);
        chk("op_count", int'(instr_count), 0);
        do_reset();
        tick(1);
        chk("op_rst_state", int'(state), 0);
        chk("op_rst_halted", int'(halted), 0);
        chk("op_rst_cause", int'(halt_cause), 0);
        drain("op_drain");

        // Step button held through reset
        bp_en = 1'b0;
        step_pb = 1'b1;
        do_reset();
        tick(3);
        chk("held_state", int'(state), 0);
        chk("held_count", int'(instr_count), 0);
        step_pb = 1'b0;
        tick(1);
        press_step(1'b1);
        chk("held_then_press", int'(instr_count), 1);

        // run_sw beats a simultaneous step edge, which is then lost
        run_sw = 1'b1;
        step_pb = 1'b1;
        tick(1);
        chk("run_prio_state", int'(state), 2);
        run_sw = 1'b0;
        tick(1);
        chk("run_prio_idle", int'(state), 0);
        step_pb = 1'b0;
        tick(3);
        chk("run_prio_count", int'(instr_count), 1);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
